// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide request and HI/LO result bundle.
// The EX control logic drives the master side; the muldiv unit is the slave.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] oprd1_i;
    logic [WIDTH-1:0] oprd2_i;
    logic             annul_i;
    logic             stall_o;
    logic             ready_o;
    logic             hilo_en_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, oprd1_i, oprd2_i, annul_i,
        input  stall_o, ready_o, hilo_en_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, oprd1_i, oprd2_i, annul_i,
        output stall_o, ready_o, hilo_en_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage. Multiplies use a
// pipelined product register chain; divides use a restoring divider that
// produces one quotient bit per cycle. Results go to the HI/LO write path.
module ex_muldiv #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    // Counter also times the multiply latency, so widen it if that needs more bits.
    localparam int CW = (CNT_W >= $clog2(MUL_LATENCY + 1)) ? CNT_W : $clog2(MUL_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, DIV0, DONE} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CW-1:0]      r_cnt;
    logic               r_mul_uns;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_stall;
    logic               w_accept;
    logic               w_finish;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [2*WIDTH-1:0] w_ea;
    logic [2*WIDTH-1:0] w_eb;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;

    // Divider operands are converted to magnitudes at accept time.
    assign w_sgn  = ~bus.op_i[0];
    assign w_abs1 = (w_sgn && bus.oprd1_i[WIDTH-1]) ? -bus.oprd1_i : bus.oprd1_i;
    assign w_abs2 = (w_sgn && bus.oprd2_i[WIDTH-1]) ? -bus.oprd2_i : bus.oprd2_i;

    // Extending both operands to 2*WIDTH makes the truncated product correct
    // for signed and unsigned alike.
    assign w_ea   = r_mul_uns ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_eb   = r_mul_uns ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod = w_ea * w_eb;

    // One restoring-division step: shift in next dividend bit, try subtract.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_dvsr};
    assign w_rem_nx = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

    generate
        if (MUL_LATENCY > 1) begin : g_chain
            logic [2*WIDTH-1:0] r_pipe [MUL_LATENCY-1];

            // Free-running product delay line; its tail is sampled on entry to DONE.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int unsigned i = 0; i < MUL_LATENCY - 1; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_prod;
                    for (int unsigned i = 1; i < MUL_LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_mul_res = r_pipe[MUL_LATENCY-2];
        end else begin : g_nochain
            assign w_mul_res = w_prod;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    // Next-state and stall request.
    always_comb begin
        w_state_nx = r_state;
        w_stall    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    w_stall = 1'b1;
                    if (!bus.op_i[1])          w_state_nx = MUL;
                    else if (bus.oprd2_i == '0) w_state_nx = DIV0;
                    else                       w_state_nx = DIV;
                end
            end
            MUL: begin
                w_stall = 1'b1;
                if (bus.annul_i)                            w_state_nx = IDLE;
                else if (r_cnt == CW'(MUL_LATENCY - 1))     w_state_nx = DONE;
            end
            DIV: begin
                w_stall = 1'b1;
                if (bus.annul_i)                w_state_nx = IDLE;
                else if (r_cnt == CW'(WIDTH))   w_state_nx = DONE;
            end
            DIV0: begin
                w_stall    = 1'b1;
                w_state_nx = bus.annul_i ? IDLE : DONE;
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        if (bus.annul_i) w_stall = 1'b0;
    end

    assign w_accept = (r_state == IDLE) && (w_state_nx != IDLE);
    assign w_finish = (r_state != DONE) && (w_state_nx == DONE);

    // Operand capture, iteration counter, divider steps and HI/LO result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_mul_uns <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_mul_uns <= bus.op_i[0];
                r_a       <= bus.oprd1_i;
                r_b       <= bus.oprd2_i;
                r_rem     <= '0;
                r_quo     <= w_abs1;
                r_dvsr    <= w_abs2;
                r_neg_q   <= w_sgn & (bus.oprd1_i[WIDTH-1] ^ bus.oprd2_i[WIDTH-1]);
                r_neg_r   <= w_sgn & bus.oprd1_i[WIDTH-1];
            end else if (r_state == MUL || r_state == DIV) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == DIV && r_cnt != CW'(WIDTH)) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
            end

            if (w_finish) begin
                unique case (r_state)
                    MUL: {r_hi, r_lo} <= w_mul_res;
                    DIV: begin
                        r_hi <= r_neg_r ? -r_rem : r_rem;
                        r_lo <= r_neg_q ? -r_quo : r_quo;
                    end
                    DIV0: begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.stall_o   = w_stall;
    assign bus.ready_o   = (r_state == DONE);
    assign bus.hilo_en_o = (r_state == DONE);
    assign bus.hi_o      = r_hi;
    assign bus.lo_o      = r_lo;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv with a cycle-exact result scoreboard.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv #(.WIDTH(32), .MUL_LATENCY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    int   t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: ready/hilo_en must pulse exactly in the expected cycle with the expected data.
    always @(negedge clk) begin
        if (mon_en) begin
            automatic bit   exp_rdy = (q.size() > 0) && (q[0].cyc == cyc);
            automatic exp_t e;
            chk("ready", {31'b0, bus.ready_o}, {31'b0, exp_rdy});
            chk("hilo_en", {31'b0, bus.hilo_en_o}, {31'b0, exp_rdy});
            if (exp_rdy) begin
                e = q.pop_front();
                chk("hi", bus.hi_o, e.hi);
                chk("lo", bus.lo_o, e.lo);
            end
        end
    end

    // Present one op for a single cycle; t returns the cycle count of the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int lat,
                         input bit push, input bit watch, output int tacc);
        exp_t e;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.oprd1_i = a;
        bus.oprd2_i = b;
        #1 chk("stall_req", {31'b0, bus.stall_o}, 32'd1);
        tacc = cyc + 1;
        if (push) begin
            e.hi = eh; e.lo = el; e.cyc = tacc + lat;
            q.push_back(e);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        if (watch) begin
            for (int i = 0; i < lat; i++) begin
                if (i > 0) @(negedge clk);
                #1 chk("stall_busy", {31'b0, bus.stall_o}, 32'd1);
            end
            @(negedge clk);
            #1 chk("stall_done", {31'b0, bus.stall_o}, 32'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst         = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.oprd1_i = '0;
        bus.oprd2_i = '0;
        bus.annul_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", bus.hi_o, 32'h0);
        chk("rst_lo", bus.lo_o, 32'h0);
        chk("rst_stall", {31'b0, bus.stall_o}, 32'd0);
        chk("rst_ready", {31'b0, bus.ready_o}, 32'd0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Multiplies and divides, back-to-back where the task allows it.
        issue(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 3, 1, 1, t);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3, 1, 1, t);
        repeat (3) @(negedge clk);
        chk("hold_hi", bus.hi_o, 32'hFFFFFFFE);
        chk("hold_lo", bus.lo_o, 32'h00000001);
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1, 1, t);
        issue(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1, 1, t);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1, 1, t);
        issue(2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1,  1, 1, t);
        issue(2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1,  1, 1, t);
        issue(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3,  1, 1, t);
        issue(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 3,  1, 1, t);
        issue(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1, 1, t);
        drain();

        // start_i held through DONE: only the IDLE cycle after DONE accepts again.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.oprd1_i = 32'd2;
        bus.oprd2_i = 32'd3;
        t = cyc + 1;
        e.hi = 32'd0; e.lo = 32'd6; e.cyc = t + 3; q.push_back(e);
        e.cyc = t + 8; q.push_back(e);
        repeat (6) @(negedge clk);
        bus.start_i = 1'b0;
        drain();

        // Flush mid-divide: no write, result registers keep the previous value.
        issue(2'b10, 32'd1000, 32'd3, 32'd0, 32'd0, 33, 0, 0, t);
        repeat (9) @(negedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        #1 chk("annul_stall", {31'b0, bus.stall_o}, 32'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        #1;
        chk("annul_idle_stall", {31'b0, bus.stall_o}, 32'd0);
        chk("annul_hi", bus.hi_o, 32'd0);
        chk("annul_lo", bus.lo_o, 32'd6);
        issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 3, 1, 1, t);
        drain();

        // Flush together with start in IDLE: nothing accepted.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.oprd1_i = 32'd9;
        bus.oprd2_i = 32'd9;
        bus.annul_i = 1'b1;
        #1 chk("annul_start_stall", {31'b0, bus.stall_o}, 32'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("annul_start_lo", bus.lo_o, 32'd42);

        // Flush during DONE does not cancel the write.
        issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 3, 1, 0, t);
        repeat (2) @(negedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b0;
        drain();
        chk("done_annul_lo", bus.lo_o, 32'd15);

        // Reset mid-divide clears results and never pulses ready.
        issue(2'b11, 32'd50, 32'd5, 32'd0, 32'd0, 33, 0, 0, t);
        repeat (4) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_hi", bus.hi_o, 32'd0);
        chk("mrst_lo", bus.lo_o, 32'd0);
        chk("mrst_stall", {31'b0, bus.stall_o}, 32'd0);
        chk("mrst_ready", {31'b0, bus.ready_o}, 32'd0);
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised, multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Executes MULT/MULTU/DIV/DIVU and produces a HI/LO write (enable, hi, lo) for the MEM/WB HI/LO path.
- Holds the pipeline through a stall request while the operation is in flight.
- Generalises the EX HI/LO path to WIDTH-bit operands, a configurable multiplier latency, an iterative divider, and flush support.

Parameters:
- WIDTH, 32, operand width; hi_o and lo_o are each WIDTH bits.
- MUL_LATENCY, 3, cycles from accepted start to result for multiplies; must be >= 1.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; RST_ENABLE is 0.
- start_i  in  1  EX has a mul/div instruction this cycle.
- op_i  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- oprd1_i  in  WIDTH  multiplicand / dividend (rs).
- oprd2_i  in  WIDTH  multiplier / divisor (rt).
- annul_i  in  1  flush: abort the current or requested operation.
- stall_o  out  1  request pipeline stall.
- ready_o  out  1  one-cycle pulse: hi_o/lo_o valid this cycle.
- hilo_en_o  out  1  HI/LO write enable; equal to ready_o.
- hi_o  out  WIDTH  product upper half / remainder.
- lo_o  out  WIDTH  product lower half / quotient.

Behaviour:
- States: IDLE, MUL, DIV, DIV0, DONE.
- Reset (rst==0 at an edge, any state including mid-operation):
  - State goes to IDLE and the counter clears.
  - hi_o, lo_o and all internal registers go to 0.
  - ready_o, hilo_en_o and stall_o are 0 in the following cycle.
- Accept: in IDLE with start_i=1 and annul_i=0, latch op_i and operands at edge T.
  - op_i[1]=0 goes to MUL.
  - op_i[1]=1 with oprd2_i==0 goes to DIV0.
  - Otherwise op_i[1]=1 goes to DIV.
- stall_o is combinational:
  - 1 when (IDLE and start_i and not annul_i), or state is MUL or DIV or DIV0.
  - Forced to 0 whenever annul_i=1.
  - 0 in DONE, so the pipeline advances in the cycle the result is presented.
- MUL: full 2*WIDTH-bit product, signed for MULT, unsigned for MULTU.
  - Passes through a MUL_LATENCY-1 deep register chain.
  - ready_o is high in cycle T+MUL_LATENCY.
- DIV: restoring divider, one quotient bit per cycle.
  - Signed ops divide absolute values first.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Counter runs WIDTH iterations, then the sign fix-up is applied on the transition into DONE.
  - ready_o is high in cycle T+WIDTH+1.
  - Signed most-negative / -1 wraps: lo = 1<<(WIDTH-1), hi = 0, no exception.
- DIV0: one cycle, then DONE; ready_o is high at T+1. Result is hi = dividend, lo = all ones (signed and unsigned alike).
- DONE: lasts one cycle.
  - ready_o=1 and hilo_en_o=1; hi_o/lo_o are updated on entry to DONE.
  - Then goes to IDLE; start_i is ignored in DONE, because the instruction in EX is still the one completing.
- hi_o/lo_o hold the last result until the next completion; they are never cleared by annul_i.
- annul_i=1 in MUL/DIV/DIV0: go to IDLE at the next edge, with no ready_o pulse and no HI/LO write.
- annul_i=1 together with start_i in IDLE: nothing is accepted.
- annul_i in DONE has no effect: the write still occurs.
- Back-to-back: a start_i in the cycle after DONE is accepted normally.

Test Plan:
- Reset for 2 cycles, then MULT 0xFFFFFFFD * 0x00000007 at T -> stall_o=1 for T..T+2; at T+3: ready_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; stall_o=0.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001 at T+3; the result is held until the next op.
- DIV 0xFFFFFFF9 (-7) / 2 -> ready_o exactly at T+33: lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 100/7 -> lo_o=14, hi_o=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0; DIVU 5/0 -> ready_o at T+1, hi_o=5, lo_o=0xFFFFFFFF.
- DIV started, annul_i pulsed at T+10 -> IDLE at T+11, stall_o=0, no ready_o, hi_o/lo_o unchanged; a new MULT at T+12 is accepted.
- rst=0 at T+5 during DIV -> at T+6 state is IDLE, hi_o=lo_o=0, stall_o=0, ready_o never pulses.
